// File: rtl/bram_reader.sv
// Streams a burst of words from a single-port synchronous block RAM to a
// ready/valid output through a two-entry registered buffer, with optional looping.
module bram_reader #(
    parameter int WordLengthBits = 8,
    parameter int NumWords       = 128,
    localparam int AddrBits      = $clog2(NumWords)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [AddrBits-1:0]       start_address,
    input  logic [AddrBits:0]         length,
    input  logic                      loop,
    output logic                      busy,
    output logic                      done,
    output logic [AddrBits-1:0]       bram_address,
    output logic                      bram_write_enable,
    input  logic [WordLengthBits-1:0] bram_data,
    output logic [WordLengthBits-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [AddrBits:0]   LenZero  = {(AddrBits + 1){1'b0}};
    localparam logic [AddrBits:0]   LenOne   = {{AddrBits{1'b0}}, 1'b1};
    localparam logic [AddrBits-1:0] AddrZero = {AddrBits{1'b0}};
    localparam logic [AddrBits-1:0] AddrOne  = {{(AddrBits - 1){1'b0}}, 1'b1};
    localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NumWords - 1);

    state_t                    state_r;
    state_t                    state_s;
    logic [AddrBits-1:0]       start_addr_r;
    logic [AddrBits-1:0]       rd_ptr_r;
    logic [AddrBits:0]         len_r;
    logic [AddrBits:0]         issued_r;
    logic [AddrBits:0]         xfer_r;
    logic                      loop_r;
    logic                      first_r;
    logic                      inflight_r;
    logic                      done_r;
    logic                      valid_r;
    logic [1:0]                cnt_r;
    logic [WordLengthBits-1:0] head_r;
    logic [WordLengthBits-1:0] skid_r;

    logic                      pop_s;
    logic                      land_s;
    logic [2:0]                occ_s;
    logic                      issue_s;
    logic                      last_issue_s;
    logic                      last_xfer_s;
    logic [AddrBits-1:0]       ptr_inc_s;

    assign busy              = (state_r != IDLE);
    assign done              = done_r;
    assign bram_address      = rd_ptr_r;
    assign bram_write_enable = 1'b0;
    assign out_data          = head_r;
    assign out_valid         = valid_r;

    // Issue decision and next-state logic; occupancy counts the word leaving this cycle.
    always_comb begin
        pop_s        = valid_r & out_ready;
        land_s       = inflight_r;
        occ_s        = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        last_issue_s = (issued_r == (len_r - LenOne));
        last_xfer_s  = pop_s & (xfer_r == (len_r - LenOne));
        issue_s      = (state_r == STREAM) & ~stop & ~first_r & (occ_s < 3'd2);
        ptr_inc_s    = (rd_ptr_r == LastAddr) ? AddrZero : (rd_ptr_r + AddrOne);
        state_s      = state_r;
        case (state_r)
            IDLE: begin
                if (start && (length != LenZero)) begin
                    state_s = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (issue_s && last_issue_s && !loop_r) begin
                    state_s = DRAIN;
                end else begin
                    state_s = STREAM;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (last_xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst parameters, read pointer, pass counters and the two-entry output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_addr_r <= AddrZero;
            rd_ptr_r     <= AddrZero;
            len_r        <= LenZero;
            issued_r     <= LenZero;
            xfer_r       <= LenZero;
            loop_r       <= 1'b0;
            first_r      <= 1'b0;
            inflight_r   <= 1'b0;
            done_r       <= 1'b0;
            valid_r      <= 1'b0;
            cnt_r        <= 2'd0;
            head_r       <= {WordLengthBits{1'b0}};
            skid_r       <= {WordLengthBits{1'b0}};
        end else begin
            done_r  <= 1'b0;
            first_r <= 1'b0;
            if (state_r == IDLE) begin
                if (start) begin
                    start_addr_r <= start_address;
                    rd_ptr_r     <= start_address;
                    len_r        <= length;
                    loop_r       <= loop;
                    issued_r     <= LenZero;
                    xfer_r       <= LenZero;
                    // One settling cycle before the first read sets the output latency.
                    first_r      <= (length != LenZero);
                    done_r       <= (length == LenZero);
                end
            end else if (stop) begin
                cnt_r      <= 2'd0;
                inflight_r <= 1'b0;
                valid_r    <= 1'b0;
            end else begin
                inflight_r <= issue_s;
                if (issue_s) begin
                    if (last_issue_s && loop_r) begin
                        issued_r <= LenZero;
                        rd_ptr_r <= start_addr_r;
                    end else begin
                        issued_r <= issued_r + LenOne;
                        rd_ptr_r <= ptr_inc_s;
                    end
                end
                if (pop_s) begin
                    if (last_xfer_s) begin
                        xfer_r <= LenZero;
                        done_r <= 1'b1;
                    end else begin
                        xfer_r <= xfer_r + LenOne;
                    end
                end
                case ({pop_s, land_s})
                    2'b01: begin
                        if (cnt_r == 2'd0) begin
                            head_r <= bram_data;
                        end else begin
                            skid_r <= bram_data;
                        end
                        cnt_r   <= cnt_r + 2'd1;
                        valid_r <= 1'b1;
                    end
                    2'b10: begin
                        head_r  <= skid_r;
                        cnt_r   <= cnt_r - 2'd1;
                        valid_r <= (cnt_r == 2'd2);
                    end
                    2'b11: begin
                        if (cnt_r == 2'd1) begin
                            head_r <= bram_data;
                        end else begin
                            head_r <= skid_r;
                            skid_r <= bram_data;
                        end
                        valid_r <= 1'b1;
                    end
                    default: begin
                        valid_r <= (cnt_r != 2'd0);
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/bram_reader.md
BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 SHALL have parameter WordLengthBits, default 8, meaning width of one memory word.
REQ-002 SHALL have parameter NumWords, default 128, meaning depth of the attached single-port synchronous block RAM; AddrBits = $clog2(NumWords).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort request; sampled in any non-IDLE state.
REQ-007 SHALL have port start_address  input  AddrBits  first word of burst; captured when start is accepted.
REQ-008 SHALL have port length  input  AddrBits+1  words per pass, 0..NumWords; captured when start is accepted.
REQ-009 SHALL have port loop  input  1  repeat the pass until stop; captured when start is accepted.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of each pass.
REQ-012 SHALL have port bram_address  output  AddrBits  read address to RAM.
REQ-013 SHALL have port bram_write_enable  output  1  tied to 0; this block never writes.
REQ-014 SHALL have port bram_data  input  WordLengthBits  RAM read data, valid one cycle after the address is presented.
REQ-015 SHALL have ports out_data  output  WordLengthBits, out_valid  output  1, out_ready  input  1  output stream; word transfers when out_valid and out_ready are both high on a rising edge.

Function
REQ-016 SHALL implement states IDLE, STREAM, DRAIN.
REQ-017 IDLE -> STREAM on start with length != 0; start with length == 0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-018 In STREAM, a read SHALL be issued in a cycle only when (words buffered + reads in flight) < 2; the read pointer then increments.
REQ-019 The read pointer SHALL wrap modulo NumWords (NumWords-1 -> 0).
REQ-020 The output buffer SHALL hold 2 entries in FIFO order; out_data/out_valid SHALL come from registers, never combinationally from bram_data.
REQ-021 With out_ready held high, throughput SHALL be one word per cycle with no bubbles, including across loop restarts.
REQ-022 out_valid SHALL first assert on the 3rd rising edge after the edge that accepted start.
REQ-023 Once out_valid is high, out_data SHALL hold stable until transferred.
REQ-024 When the last read of a pass is issued: with loop=1 the pointer SHALL reload start_address and STREAM continues; with loop=0 the state SHALL go to DRAIN.
REQ-025 done SHALL pulse in the cycle after the last word of a pass transfers; in loop mode once per pass.
REQ-026 DRAIN -> IDLE when the buffer is empty and no read is in flight, coincident with the done pulse.
REQ-027 stop in STREAM or DRAIN SHALL, on the next edge, clear the buffer, discard in-flight data, deassert out_valid, enter IDLE; no done pulse.
REQ-028 stop and the final transfer on the same edge: stop wins; no done.
REQ-029 start while busy SHALL be ignored, and captured parameters SHALL not change mid-burst.
REQ-030 length == NumWords SHALL read every word exactly once per pass, wrapping if start_address != 0.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, empty buffer, out_valid=0, busy=0, done=0, bram_address=0, out_data=0, regardless of clock.
REQ-032 Reset mid-burst SHALL abandon the burst; no word or done SHALL be emitted after release until a new start.

Verification
REQ-033 RAM preloaded word[i]=i; start_address=5, length=4, loop=0, out_ready=1 -> 5,6,7,8 on consecutive cycles, first out_valid 3 edges after start, one done pulse, then busy=0.
REQ-034 start_address=126, length=4, NumWords=128 -> 126,127,0,1.
REQ-035 length=6, out_ready toggled 1,0,0,1 repeating -> exactly 6 words in order, none duplicated or lost, out_data stable while stalled.
REQ-036 loop=1, start_address=0, length=3, stop after 8 transfers -> 0,1,2,0,1,2,0,1, two done pulses, out_valid low the cycle after stop, no further done.
REQ-037 length=0 -> done pulses next cycle, out_valid never asserts; start with busy=1 -> ignored.
REQ-038 rst asserted asynchronously mid-burst -> all outputs zero immediately, burst not resumed after release.
